md_unit: RTL and testbench

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo from the E-stage operands and holds the HI/LO registers. It drives `busy`, which the hazard unit ORs with its `start` signal to stall md-class instructions in D. It also drives the HI/LO read value used by mfhi/mflo. Interrupt/exception flush suppresses the E-stage operation in the cycle it is asserted.

---
 rtl/md_unit.sv | 118 +++++++++++
 tb/tb_md_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the E stage. An operation launches when idle and
// commits its result to HI/LO a fixed number of cycles later, unless it divided by zero.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        hilo_sel,
  output logic        busy,
  output logic [31:0] hilo_out
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [CW-1:0]      r_cnt;
  logic [31:0]        r_res_hi;
  logic [31:0]        r_res_lo;
  logic               r_div0;

  logic               w_idle;
  logic               w_launch;
  logic signed [63:0] w_smul;
  logic [63:0]        w_umul;
  logic [31:0]        w_ua;
  logic [31:0]        w_ub;
  logic [31:0]        w_ub_safe;
  logic [31:0]        w_uq;
  logic [31:0]        w_ur;
  logic [31:0]        w_sq;
  logic [31:0]        w_sr;
  logic [31:0]        w_udq;
  logic [31:0]        w_udr;
  logic [31:0]        w_B_safe;

  assign w_idle   = (r_cnt == '0);
  assign w_launch = start && !flush && w_idle && (md_op >= OP_MULT) && (md_op <= OP_DIVU);

  assign w_smul = $signed(A) * $signed(B);
  assign w_umul = {32'd0, A} * {32'd0, B};

  // Signed divide through magnitudes so that 0x80000000 / -1 wraps to 0x80000000
  // instead of relying on native signed overflow behaviour.
  assign w_ua      = A[31] ? (~A + 32'd1) : A;
  assign w_ub      = B[31] ? (~B + 32'd1) : B;
  assign w_ub_safe = (w_ub == 32'd0) ? 32'd1 : w_ub;
  assign w_uq      = w_ua / w_ub_safe;
  assign w_ur      = w_ua % w_ub_safe;
  assign w_sq      = (A[31] ^ B[31]) ? (~w_uq + 32'd1) : w_uq;
  assign w_sr      = A[31] ? (~w_ur + 32'd1) : w_ur;

  assign w_B_safe  = (B == 32'd0) ? 32'd1 : B;
  assign w_udq     = A / w_B_safe;
  assign w_udr     = A % w_B_safe;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_div0   <= 1'b0;
    end else if (!w_idle) begin
      // In-flight ops ignore flush: they belong to an already committed instruction.
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1) && !r_div0) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end
    end else if (w_launch) begin
      r_div0 <= 1'b0;
      case (md_op)
        OP_MULT: begin
          {r_res_hi, r_res_lo} <= w_smul;
          r_cnt                <= CW'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {r_res_hi, r_res_lo} <= w_umul;
          r_cnt                <= CW'(MULT_CYCLES);
        end
        OP_DIV: begin
          r_res_hi <= w_sr;
          r_res_lo <= w_sq;
          r_div0   <= (B == 32'd0);
          r_cnt    <= CW'(DIV_CYCLES);
        end
        default: begin
          r_res_hi <= w_udr;
          r_res_lo <= w_udq;
          r_div0   <= (B == 32'd0);
          r_cnt    <= CW'(DIV_CYCLES);
        end
      endcase
    end else if (!flush) begin
      if (md_op == OP_MTHI) r_hi <= A;
      if (md_op == OP_MTLO) r_lo <= A;
    end
  end

  assign busy     = !w_idle;
  assign hilo_out = hilo_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: an edge-scheduled transaction model checked every cycle,
// plus literal expectations for each scenario.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        hilo_sel;
  logic        busy;
  logic [31:0] hilo_out;

  int n_vec  = 0;
  int n_fail = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .flush(flush), .hilo_sel(hilo_sel), .busy(busy), .hilo_out(hilo_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // A launch at edge e schedules its result for edge e+N; busy means a result is pending.
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  logic        m_pend = 1'b0;
  logic        m_div0;
  logic        m_valid = 1'b0;
  int          m_edge = 0;
  int          m_end;

  always @(posedge clk) begin
    longint sa, sb, sq, sr;
    m_edge++;
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_pend = 0; m_valid = 1;
    end else if (m_pend) begin
      if (m_edge == m_end) begin
        if (!m_div0) {m_hi, m_lo} = m_res;
        m_pend = 0;
      end
    end else if (!flush) begin
      if (start && md_op >= 3'd1 && md_op <= 3'd4) begin
        m_pend = 1;
        m_div0 = 0;
        sa = longint'($signed(A));
        sb = longint'($signed(B));
        case (md_op)
          3'd1: begin m_res = 64'(sa * sb); m_end = m_edge + 5; end
          3'd2: begin m_res = {32'd0, A} * {32'd0, B}; m_end = m_edge + 5; end
          3'd3: begin
            m_end = m_edge + 10;
            if (B == 0) m_div0 = 1;
            else begin
              sq = sa / sb;
              sr = sa % sb;
              m_res = {sr[31:0], sq[31:0]};
            end
          end
          default: begin
            m_end = m_edge + 10;
            if (B == 0) m_div0 = 1;
            else m_res = {A % B, A / B};
          end
        endcase
      end else if (md_op == 3'd5) m_hi = A;
      else if (md_op == 3'd6) m_lo = A;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_busy", {31'd0, busy}, {31'd0, m_pend});
      check("model_hilo", hilo_out, hilo_sel ? m_hi : m_lo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    start = 0; md_op = 0; A = 0; B = 0; flush = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic fl);
    md_op = op; A = a; B = b; start = st; flush = fl;
    step();
    idle();
  endtask

  task automatic check_hilo(input string nm, input logic [31:0] hi, input logic [31:0] lo);
    hilo_sel = 1; #1;
    check({nm, "_hi"}, hilo_out, hi);
    hilo_sel = 0; #1;
    check({nm, "_lo"}, hilo_out, lo);
  endtask

  // mode 1: flush on the 2nd busy cycle; mode 2: a competing divu start on the 2nd busy cycle
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int exp_n, input int mode);
    int n;
    issue(op, a, b, 1, 0);
    n = 0;
    while (busy && n < 50) begin
      n++;
      if (n == 2 && mode == 1) flush = 1;
      if (n == 2 && mode == 2) begin start = 1; md_op = 3'd4; A = 100; B = 3; end
      step();
      idle();
    end
    check({nm, "_busy_cycles"}, 32'(n), 32'(exp_n));
    check_hilo(nm, hi, lo);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    hilo_sel = 0;
    reset = 0;
    step(); step();
    reset = 1;
    step();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check_hilo("reset", 32'h0, 32'h0);

    run_op("mult",  3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5, 0);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5, 0);
    run_op("div",   3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0);
    run_op("divu",  3'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10, 0);

    issue(3'd5, 32'h1234, 32'd0, 0, 0);
    issue(3'd6, 32'h5678, 32'd0, 0, 0);
    check_hilo("mthi_mtlo", 32'h1234, 32'h5678);
    run_op("div0",  3'd3, 32'd77, 32'd0,              32'h1234, 32'h5678, 10, 0);
    run_op("divovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10, 0);

    issue(3'd1, 32'd5, 32'd7, 1, 1);
    for (int i = 0; i < 3; i++) begin
      check("flush_start_busy", {31'd0, busy}, 32'd0);
      step();
    end
    check_hilo("flush_start", 32'h0, 32'h80000000);

    issue(3'd6, 32'hAA, 32'd0, 0, 1);
    check_hilo("flush_mtlo", 32'h0, 32'h80000000);

    run_op("flush_busy", 3'd1, 32'h10000, 32'h10000, 32'h1, 32'h0, 5, 1);
    run_op("start_busy", 3'd2, 32'd6, 32'd7, 32'h0, 32'd42, 5, 2);
    step();
    check("after_start_busy", {31'd0, busy}, 32'd0);

    issue(3'd3, 32'd100, 32'd7, 1, 0);
    step(); step();
    reset = 0;
    step();
    reset = 1;
    check("reset_mid_busy", {31'd0, busy}, 32'd0);
    check_hilo("reset_mid", 32'h0, 32'h0);
    for (int i = 0; i < 12; i++) step();
    check_hilo("reset_no_late_write", 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
